chacha_arbiter: RTL and testbench
=================================

CHACHA_ARBITER -- requirements
Module: chacha_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles spent in WAIT before the job is aborted with an error.
REQ-002 Parameter ROUNDS, default 20: value driven on core_rounds.
REQ-003 chacha_arb_clk  input  1  single clock; all logic is on the rising edge.
REQ-004 chacha_arb_reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester N (0 = encrypt path, 1 = decrypt path) presents a job.
REQ-006 req0_ready / req1_ready  output  1 each  the job is accepted on the cycle where reqN_valid and reqN_ready are both high.
REQ-007 reqN_key  input  256  key for requester N.
REQ-008 reqN_nonce  input  64  nonce for requester N.
REQ-009 reqN_counter  input  64  block counter for requester N.
REQ-010 reqN_data  input  512  plaintext or ciphertext block for requester N.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_id  output  1  index of the requester that owns the result.
REQ-014 rsp_data  output  512  core result block.
REQ-015 rsp_err  output  1  job ended by timeout.
REQ-016 core_init  output  1  one-cycle start pulse to the chacha core.
REQ-017 core_key  output  256  key to the core.
REQ-018 core_iv  output  64  nonce to the core.
REQ-019 core_ctr  output  64  counter to the core.
REQ-020 core_data_in  output  512  data block to the core.
REQ-021 core_rounds  output  5  round count to the core.
REQ-022 core_data_out  input  512  core result.
REQ-023 core_data_out_valid  input  1  core result valid; may remain high after completion until the next init.

Function
REQ-024 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE; one job is in flight at a time.
REQ-025 IDLE grant rules:
- grant is combinational.
- reqN_ready = (state == IDLE) && (grant == N).
- Only one ready SHALL be high in any cycle.
REQ-026 Arbitration SHALL be round-robin:
- If only one requester is valid, it is granted.
- If both are valid, the requester not equal to last_grant is granted.
- last_grant resets to 1, so req0 wins the first contention.
REQ-027 On acceptance:
- key, nonce, counter, data and id SHALL be latched into core_key, core_iv, core_ctr, core_data_in and an owner register.
- last_grant SHALL be updated.
- The FSM SHALL move to ISSUE.
REQ-028 ISSUE SHALL last exactly 1 cycle with core_init = 1; core_init SHALL be 0 in every other state.
REQ-029 Core operands SHALL stay stable from ISSUE until the FSM returns to IDLE.
REQ-030 Stale-valid filter: a seen_low flag is cleared in ISSUE and set on any WAIT cycle where core_data_out_valid = 0.
REQ-031 WAIT completes on the first cycle with core_data_out_valid = 1 and seen_low = 1:
- rsp_data <= core_data_out, rsp_err <= 0.
- Go to RESPOND.
REQ-032 Watchdog counter:
- Cleared in ISSUE and incremented each WAIT cycle.
- When it equals TIMEOUT-1 without completion: rsp_data <= 0, rsp_err <= 1, go to RESPOND.
- If completion and timeout occur in the same cycle, completion wins.
REQ-033 RESPOND:
- rsp_valid = 1.
- rsp_id, rsp_data and rsp_err SHALL be held stable until rsp_ready = 1.
- The FSM then returns to IDLE.
- rsp_valid SHALL NOT depend on rsp_ready.
REQ-034 Acceptance latency SHALL be 0 cycles in IDLE. The first result edge is at least 3 cycles after acceptance (ISSUE, minimum of one WAIT cycle with valid low, then the valid cycle).
REQ-035 Back-to-back operation:
- A new acceptance is possible in the cycle immediately after the RESPOND handshake.
- No request SHALL be accepted outside IDLE.
REQ-036 A requester's valid dropping before acceptance SHALL cancel nothing, and no ready SHALL be raised for it.

Reset
REQ-037 Asserting chacha_arb_reset at any time, including mid-job, SHALL asynchronously force:
- state = IDLE.
- core_init, rsp_valid, rsp_err, rsp_id and both ready registers to 0.
- rsp_data, core_key, core_iv, core_ctr, core_data_in, watchdog and seen_low to 0.
- last_grant = 1.
- core_rounds stays at the constant ROUNDS.
REQ-038 After reset release, the first rising edge SHALL evaluate IDLE normally; any in-flight job is discarded with no response.

Verification
REQ-039 Single job: req0 with key=0, nonce=0x1, counter=0, data=0. The core model returns after 20 cycles, with valid low in between. Required response:
- exactly one core_init pulse;
- rsp_valid with rsp_id=0, rsp_err=0 and rsp_data = model output.
REQ-040 Contention: req0 and req1 valid continuously for 4 jobs -> grant order 0,1,0,1, with a matching rsp_id sequence.
REQ-041 Stale valid: core_data_out_valid held high from the previous job, dropping 2 cycles after init and rising again at cycle 10 -> the completion is taken at cycle 10, not earlier.
REQ-042 Timeout: with TIMEOUT=16 and a core that never asserts valid -> rsp_valid with rsp_err=1 and rsp_data=0 at WAIT cycle 16.
REQ-043 Backpressure: rsp_ready held low for 50 cycles -> rsp outputs stable, both readies low, no core_init.
REQ-044 Reset mid-WAIT, asserted asynchronously between clock edges -> outputs 0 immediately. The next req1 job gets the first grant and completes normally.

Source files
------------

// File: rtl/chacha_arbiter.sv
// Round-robin front end that shares one ChaCha core between an encrypt (0)
// and a decrypt (1) requester. One job is in flight at a time, results are
// held until the consumer takes them, and a watchdog ends jobs the core
// never finishes.
module chacha_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int ROUNDS  = 20
) (
  input  logic         chacha_arb_clk,
  input  logic         chacha_arb_reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [255:0] req0_key,
  input  logic [63:0]  req0_nonce,
  input  logic [63:0]  req0_counter,
  input  logic [511:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [255:0] req1_key,
  input  logic [63:0]  req1_nonce,
  input  logic [63:0]  req1_counter,
  input  logic [511:0] req1_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [511:0] rsp_data,
  output logic         rsp_err,
  output logic         core_init,
  output logic [255:0] core_key,
  output logic [63:0]  core_iv,
  output logic [63:0]  core_ctr,
  output logic [511:0] core_data_in,
  output logic [4:0]   core_rounds,
  input  logic [511:0] core_data_out,
  input  logic         core_data_out_valid
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t         state, state_nxt;
  logic           grant;
  logic           any_valid;
  logic           accept;
  logic           done;
  logic           expired;
  logic           last_grant;
  logic           owner;
  logic           seen_low;
  logic [WDW-1:0] wdog;

  assign any_valid   = req0_valid | req1_valid;
  assign core_rounds = 5'(ROUNDS);
  assign rsp_id      = owner;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // State register.
  always_ff @(posedge chacha_arb_clk or posedge chacha_arb_reset) begin
    if (chacha_arb_reset) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  // Next-state and handshake outputs; readies only exist in IDLE and only for a valid requester.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_init  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    expired    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid && !chacha_arb_reset) begin
          req0_ready = ~grant;
          req1_ready = grant;
          accept     = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_init = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A valid left over from the previous job only counts once it has been seen low.
        done    = core_data_out_valid && seen_low;
        expired = !done && (wdog == WD_LAST);
        if (done || expired) state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job operands, ownership, watchdog, stale filter and result capture.
  always_ff @(posedge chacha_arb_clk or posedge chacha_arb_reset) begin
    if (chacha_arb_reset) begin
      core_key     <= '0;
      core_iv      <= '0;
      core_ctr     <= '0;
      core_data_in <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      wdog         <= '0;
      seen_low     <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        core_key     <= grant ? req1_key     : req0_key;
        core_iv      <= grant ? req1_nonce   : req0_nonce;
        core_ctr     <= grant ? req1_counter : req0_counter;
        core_data_in <= grant ? req1_data    : req0_data;
        owner        <= grant;
        last_grant   <= grant;
      end
      case (state)
        S_ISSUE: begin
          wdog     <= '0;
          seen_low <= 1'b0;
        end
        S_WAIT: begin
          wdog <= wdog + 1'b1;
          if (!core_data_out_valid) seen_low <= 1'b1;
          if (done) begin
            rsp_data <= core_data_out;
            rsp_err  <= 1'b0;
          end else if (expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_arbiter.sv
// Bench for chacha_arbiter: a behavioural core answers each init after a
// programmable latency, accepted jobs are queued as expected results and
// popped when responses appear. A second instance with a short watchdog
// exercises the timeout path.
`timescale 1ns/1ps
module tb_chacha_arbiter;
  localparam int ROUNDS   = 20;
  localparam int TO_SHORT = 16;

  typedef struct {
    logic           id;
    logic [511:0]   data;
    logic           err;
    int unsigned    acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [255:0] req0_key, req1_key;
  logic [63:0]  req0_nonce, req0_counter, req1_nonce, req1_counter;
  logic [511:0] req0_data, req1_data;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [511:0] rsp_data;
  logic         core_init;
  logic [255:0] core_key;
  logic [63:0]  core_iv, core_ctr;
  logic [511:0] core_data_in, core_data_out;
  logic [4:0]   core_rounds;
  logic         core_data_out_valid;

  logic         t_req0_valid, t_req0_ready, t_req1_ready;
  logic         t_rsp_valid, t_rsp_ready, t_rsp_id, t_rsp_err, t_core_init;
  logic [511:0] t_rsp_data, t_core_data_in;
  logic [255:0] t_core_key;
  logic [63:0]  t_core_iv, t_core_ctr;
  logic [4:0]   t_core_rounds;
  logic [511:0] t_core_out = {16{32'h5A5A_C3C3}};

  chacha_arbiter #(.TIMEOUT(1023), .ROUNDS(ROUNDS)) dut (
    .chacha_arb_clk(clk), .chacha_arb_reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
    .req0_nonce(req0_nonce), .req0_counter(req0_counter), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
    .req1_nonce(req1_nonce), .req1_counter(req1_counter), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .core_init(core_init),
    .core_key(core_key), .core_iv(core_iv), .core_ctr(core_ctr),
    .core_data_in(core_data_in), .core_rounds(core_rounds),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid)
  );

  chacha_arbiter #(.TIMEOUT(TO_SHORT), .ROUNDS(ROUNDS)) dut_to (
    .chacha_arb_clk(clk), .chacha_arb_reset(rst),
    .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_key(req0_key),
    .req0_nonce(req0_nonce), .req0_counter(req0_counter), .req0_data(req0_data),
    .req1_valid(1'b0), .req1_ready(t_req1_ready), .req1_key(req1_key),
    .req1_nonce(req1_nonce), .req1_counter(req1_counter), .req1_data(req1_data),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
    .rsp_data(t_rsp_data), .rsp_err(t_rsp_err), .core_init(t_core_init),
    .core_key(t_core_key), .core_iv(t_core_iv), .core_ctr(t_core_ctr),
    .core_data_in(t_core_data_in), .core_rounds(t_core_rounds),
    .core_data_out(t_core_out), .core_data_out_valid(1'b0)
  );

  int unsigned tests = 0, fails = 0;
  exp_t        sb[$];
  int unsigned glog[$];
  int unsigned init_cnt = 0, dual_rdy = 0, stray_rdy = 0;

  // Stand-in for the core's transform: any operand mix-up changes the result.
  function automatic logic [511:0] model(input logic [255:0] k, input logic [63:0] n,
                                         input logic [63:0] c, input logic [511:0] d,
                                         input logic [4:0] r);
    return d ^ {k, k} ^ {8{n ^ c}} ^ {507'b0, r};
  endfunction

  function automatic exp_t mk(input logic id, input logic [511:0] d, input logic err,
                              input int unsigned acc);
    exp_t e;
    e.id = id; e.data = d; e.err = err; e.acc = acc;
    return e;
  endfunction

  // Core model: clears valid on init (unless emulating a stale hold), answers at core_lat.
  int  core_lat   = 20;
  bit  core_stale = 1'b0;
  int  ccyc       = 1000;
  initial begin
    core_data_out_valid = 1'b0;
    core_data_out       = '0;
    forever begin
      @(negedge clk);
      if (core_init) begin
        ccyc = 0;
        if (!core_stale) core_data_out_valid = 1'b0;
      end else begin
        ccyc++;
      end
      if (core_stale && ccyc == 2) core_data_out_valid = 1'b0;
      if (ccyc == core_lat) begin
        core_data_out_valid = 1'b1;
        core_data_out = model(core_key, core_iv, core_ctr, core_data_in, core_rounds);
      end
    end
  end

  // Acceptance monitor: records grants and queues the result each job must produce.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (core_init) init_cnt++;
      if (req0_ready && req1_ready) dual_rdy++;
      if ((req0_ready && !req0_valid) || (req1_ready && !req1_valid)) stray_rdy++;
      if (req0_valid && req0_ready) begin
        sb.push_back(mk(1'b0, model(req0_key, req0_nonce, req0_counter, req0_data, 5'(ROUNDS)), 1'b0, cycle));
        glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk(1'b1, model(req1_key, req1_nonce, req1_counter, req1_data, 5'(ROUNDS)), 1'b0, cycle));
        glog.push_back(1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL bench_timeout: simulation did not reach its end");
    $fatal(1, "bench time limit");
  end

  task automatic set_req(input bit n, input logic [255:0] k, input logic [63:0] nc,
                         input logic [63:0] ct, input logic [511:0] d);
    if (n) begin
      req1_key = k; req1_nonce = nc; req1_counter = ct; req1_data = d; req1_valid = 1'b1;
    end else begin
      req0_key = k; req0_nonce = nc; req0_counter = ct; req0_data = d; req0_valid = 1'b1;
    end
  endtask

  task automatic wait_accept(input bit n, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (n ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned limit, output bit found);
    found = 1'b0;
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    glog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    #12;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b%b expected 00", req0_ready, req1_ready); end
    tests++; if (rsp_valid !== 1'b0 || core_init !== 1'b0) begin fails++; $display("FAIL rst_valid_init: got %b%b expected 00", rsp_valid, core_init); end
    tests++; if (rsp_err !== 1'b0 || rsp_id !== 1'b0) begin fails++; $display("FAIL rst_err_id: got %b%b expected 00", rsp_err, rsp_id); end
    tests++; if (rsp_data !== '0 || core_key !== '0 || core_data_in !== '0) begin fails++; $display("FAIL rst_regs: got data %h key %h expected zero", rsp_data, core_key); end
    tests++; if (core_rounds !== 5'd20 || t_core_rounds !== 5'd20) begin fails++; $display("FAIL rst_rounds: got %0d/%0d expected 20", core_rounds, t_core_rounds); end
    req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok, found;
    exp_t e;
    int unsigned i0;
    core_lat = 20; core_stale = 1'b0;
    i0 = init_cnt;
    @(posedge clk); #1;
    set_req(1'b0, '0, 64'h1, 64'h0, '0);
    wait_accept(1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_accept: got no acceptance expected one"); end
    wait_rsp(40, found);
    tests++;
    if (!found || sb.size() == 0) begin
      fails++; $display("FAIL single_rsp: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data) begin fails++; $display("FAIL single_data: got %h expected %h", rsp_data, e.data); end
      tests++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL single_id_err: got %b%b expected 00", rsp_id, rsp_err); end
      tests++; if (cycle !== e.acc + 22) begin fails++; $display("FAIL single_latency: got %0d expected %0d", cycle - e.acc, 22); end
    end
    @(negedge clk);
    tests++; if (init_cnt - i0 !== 1) begin fails++; $display("FAIL single_init_count: got %0d expected 1", init_cnt - i0); end
  endtask

  task automatic test_contention();
    bit found;
    exp_t e;
    int unsigned prev_rsp;
    int unsigned order[4] = '{0, 1, 0, 1};
    pulse_reset();
    core_lat = 4;
    set_req(1'b0, {8{32'h0123_4567}}, 64'hA0, 64'h10, {16{32'hDEAD_BEEF}});
    set_req(1'b1, {8{32'h89AB_CDEF}}, 64'hB1, 64'h20, {16{32'h1234_5678}});
    prev_rsp = 0;
    for (int unsigned j = 0; j < 4; j++) begin
      wait_rsp(30, found);
      tests++;
      if (!found || sb.size() == 0) begin
        fails++; $display("FAIL cont_rsp%0d: got no response expected one", j);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== 1'(order[j]) || rsp_data !== e.data || rsp_err !== 1'b0) begin
          fails++; $display("FAIL cont_rsp%0d: got id %0d err %b expected id %0d err 0", j, rsp_id, rsp_err, order[j]);
        end
        if (j > 0) begin
          tests++; if (e.acc !== prev_rsp + 1) begin fails++; $display("FAIL cont_b2b%0d: got accept at %0d expected %0d", j, e.acc, prev_rsp + 1); end
        end
        prev_rsp = cycle;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (glog.size() < 4) begin
      fails++; $display("FAIL cont_order: got %0d grants expected at least 4", glog.size());
    end else if (glog[0] !== 0 || glog[1] !== 1 || glog[2] !== 0 || glog[3] !== 1) begin
      fails++; $display("FAIL cont_order: got %0d%0d%0d%0d expected 0101", glog[0], glog[1], glog[2], glog[3]);
    end
  endtask

  task automatic test_stale();
    bit ok, found;
    exp_t e;
    core_stale = 1'b1; core_lat = 10;
    tests++; if (core_data_out_valid !== 1'b1) begin fails++; $display("FAIL stale_setup: got core valid %b expected 1", core_data_out_valid); end
    @(posedge clk); #1;
    set_req(1'b1, {8{32'h5555_AAAA}}, 64'h77, 64'h3, {16{32'hCAFE_0001}});
    wait_accept(1'b1, ok);
    wait_rsp(40, found);
    tests++;
    if (!ok || !found || sb.size() == 0) begin
      fails++; $display("FAIL stale_rsp: got accept %b rsp %b expected 1 1", ok, found);
    end else begin
      e = sb.pop_front();
      if (cycle !== e.acc + 12) begin fails++; $display("FAIL stale_cycle: got %0d expected %0d", cycle - e.acc, 12); end
      tests++; if (rsp_data !== e.data || rsp_id !== 1'b1) begin fails++; $display("FAIL stale_data: got id %b data %h expected id 1 data %h", rsp_id, rsp_data, e.data); end
    end
    @(negedge clk);
    core_stale = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, found;
    exp_t e;
    int unsigned i0, bad;
    core_lat = 5; rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(1'b0, {8{32'h0F0F_1111}}, 64'h9, 64'h44, {16{32'h3C3C_7777}});
    wait_accept(1'b0, ok);
    wait_rsp(30, found);
    tests++;
    if (!ok || !found || sb.size() == 0) begin
      fails++; $display("FAIL bp_rsp: got accept %b rsp %b expected 1 1", ok, found);
    end else begin
      e = sb.pop_front();
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      i0 = init_cnt; bad = 0;
      for (int unsigned c = 0; c < 50; c++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data || rsp_err !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0 || core_init !== 1'b0) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
      tests++; if (init_cnt !== i0) begin fails++; $display("FAIL bp_no_init: got %0d inits expected 0", init_cnt - i0); end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got rsp_valid %b expected 0", rsp_valid); end
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned acc;
    exp_t tq[$];
    ok = 1'b0; acc = 0;
    t_rsp_ready = 1'b1;
    @(posedge clk); #1 t_req0_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      if (t_req0_ready) begin
        ok = 1'b1; acc = cycle;
        tq.push_back(mk(1'b0, '0, 1'b1, cycle));
        break;
      end
    end
    @(posedge clk); #1 t_req0_valid = 1'b0;
    ok = ok && (tq.size() != 0);
    for (int unsigned i = 0; ok && i < 40; i++) begin
      @(negedge clk);
      if (t_rsp_valid) break;
    end
    tests++;
    if (!ok || !t_rsp_valid) begin
      fails++; $display("FAIL to_rsp: got accept %b rsp %b expected 1 1", ok, t_rsp_valid);
    end else begin
      exp_t e;
      e = tq.pop_front();
      if (cycle !== acc + 18) begin fails++; $display("FAIL to_cycle: got %0d expected 18", cycle - acc); end
      tests++; if (t_rsp_err !== e.err || t_rsp_id !== e.id) begin fails++; $display("FAIL to_err_id: got %b%b expected %b%b", t_rsp_err, t_rsp_id, e.err, e.id); end
      tests++; if (t_rsp_data !== e.data) begin fails++; $display("FAIL to_data: got %h expected zero", t_rsp_data); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    exp_t e;
    int unsigned seen;
    core_lat = 20;
    @(posedge clk); #1;
    set_req(1'b0, {8{32'hFEED_0002}}, 64'h5, 64'h6, {16{32'h0000_BEEF}});
    wait_accept(1'b0, ok);
    repeat (6) @(negedge clk);
    tests++; if (core_key !== {8{32'hFEED_0002}}) begin fails++; $display("FAIL mid_key_hold: got %h expected %h", core_key, {8{32'hFEED_0002}}); end
    #2 rst = 1'b1;
    #1;
    tests++; if (core_key !== '0 || {core_iv, core_ctr, core_data_in} !== '0 || rsp_data !== '0) begin fails++; $display("FAIL mid_regs: got key %h expected zero", core_key); end
    tests++; if ({rsp_valid, rsp_err, rsp_id, core_init, req0_ready, req1_ready} !== 6'b0) begin fails++; $display("FAIL mid_ctrl: got %b expected 000000", {rsp_valid, rsp_err, rsp_id, core_init, req0_ready, req1_ready}); end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete(); glog.delete();
    seen = 0;
    for (int unsigned c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL mid_discard: got %0d response cycles expected 0", seen); end
    core_lat = 6;
    @(posedge clk); #1;
    set_req(1'b1, {8{32'h0BAD_F00D}}, 64'h12, 64'h34, {16{32'h6666_9999}});
    wait_accept(1'b1, ok);
    tests++; if (!ok || glog.size() == 0 || glog[0] !== 1) begin fails++; $display("FAIL mid_first_grant: got accept %b expected req1 granted", ok); end
    wait_rsp(30, found);
    tests++;
    if (!found || sb.size() == 0) begin
      fails++; $display("FAIL mid_rsp: got no response expected one");
    end else begin
      e = sb.pop_front();
      if (rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== e.data) begin
        fails++; $display("FAIL mid_rsp: got id %b err %b data %h expected id 1 err 0 data %h", rsp_id, rsp_err, rsp_data, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_global();
    tests++; if (dual_rdy !== 0) begin fails++; $display("FAIL one_ready: got %0d dual-ready cycles expected 0", dual_rdy); end
    tests++; if (stray_rdy !== 0) begin fails++; $display("FAIL stray_ready: got %0d ready-without-valid cycles expected 0", stray_rdy); end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_key = '0; req0_nonce = '0; req0_counter = '0; req0_data = '0;
    req1_key = '0; req1_nonce = '0; req1_counter = '0; req1_data = '0;
    rsp_ready = 1'b1;
    t_req0_valid = 1'b0; t_rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_stale();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_global();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
